// File: rtl/alu_unit.sv
// 8-bit execute-stage ALU: combinational result and Z/N/C/V flags,
// plus a condition-code register that latches flags of flag-affecting ops.
module alu_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [3:0] opcode,
   input  logic [1:0] ra,
   output logic [7:0] out,
   output logic       Z,
   output logic       N,
   output logic       C,
   output logic       V,
   output logic [3:0] ccr
);

   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_SUB   = 4'd3;
   localparam logic [3:0] OP_AND   = 4'd4;
   localparam logic [3:0] OP_OR    = 4'd5;
   localparam logic [3:0] OP_ROT   = 4'd6;
   localparam logic [3:0] OP_UNARY = 4'd8;

   logic [8:0] sum9;
   logic [8:0] diff9;
   logic [8:0] neg9;
   logic [8:0] inc9;
   logic [7:0] dec8;
   logic       flag_op;
   logic [3:0] ccr_q;
   logic [3:0] ccr_d;

   // Ninth bit of the widened sums carries out / borrows into C.
   assign sum9  = {1'b0, A} + {1'b0, B};
   assign diff9 = {1'b0, A} - {1'b0, B};
   assign neg9  = {1'b0, ~B} + 9'd1;
   assign inc9  = {1'b0, B} + 9'd1;
   assign dec8  = B - 8'd1;

   always_comb begin
      out = B;
      C   = 1'b0;
      V   = 1'b0;
      case (opcode)
         OP_ADD: begin
            out = sum9[7:0];
            C   = sum9[8];
            V   = (A[7] & B[7] & ~sum9[7]) | (~A[7] & ~B[7] & sum9[7]);
         end
         OP_SUB: begin
            out = diff9[7:0];
            C   = diff9[8];
            V   = (A[7] & ~B[7] & ~diff9[7]) | (~A[7] & B[7] & diff9[7]);
         end
         OP_AND: out = A & B;
         OP_OR:  out = A | B;
         OP_ROT: begin
            case (ra)
               2'b00: begin
                  out = {B[6:0], B[7]};
                  C   = B[7];
               end
               2'b01: begin
                  out = {B[0], B[7:1]};
                  C   = B[0];
               end
               2'b10: begin
                  out = 8'h00;
                  C   = 1'b1;
               end
               default: begin
                  out = 8'h00;
                  C   = 1'b0;
               end
            endcase
         end
         OP_UNARY: begin
            case (ra)
               2'b00: out = ~B;
               2'b01: begin
                  out = neg9[7:0];
                  C   = neg9[8];
                  V   = (B == 8'h80);
               end
               2'b10: begin
                  out = inc9[7:0];
                  C   = inc9[8];
                  V   = (B == 8'h7F);
               end
               default: begin
                  out = dec8;
                  C   = (B == 8'h00);
                  V   = (B == 8'h80);
               end
            endcase
         end
         default: out = B;
      endcase
   end

   assign Z = (out == 8'h00);
   assign N = out[7];

   assign flag_op = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
                    (opcode == OP_OR)  || (opcode == OP_ROT) || (opcode == OP_UNARY);

   always_comb begin
      ccr_d = ccr_q;
      if (flag_op) begin
         ccr_d = {V, C, N, Z};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ccr_q <= 4'b0000;
      end else begin
         ccr_q <= ccr_d;
      end
   end

   assign ccr = ccr_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: combinational result/flags per opcode
// and condition-code register capture, hold and reset behaviour.
module tb_alu_unit;

   logic       clk;
   logic       rst;
   logic [7:0] A;
   logic [7:0] B;
   logic [3:0] opcode;
   logic [1:0] ra;
   logic [7:0] out;
   logic       Z;
   logic       N;
   logic       C;
   logic       V;
   logic [3:0] ccr;

   int checks;
   int failures;

   alu_unit dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .B      (B),
      .opcode (opcode),
      .ra     (ra),
      .out    (out),
      .Z      (Z),
      .N      (N),
      .C      (C),
      .V      (V),
      .ccr    (ccr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one operation just after a falling edge and lets it settle.
   task automatic drive(input logic [3:0] op, input logic [1:0] r,
                        input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      opcode = op;
      ra     = r;
      A      = a;
      B      = b;
      #1;
   endtask

   task automatic test_reset();
      // Flag-affecting op held during reset: reset must win.
      rst    = 1'b1;
      opcode = 4'd2;
      ra     = 2'b00;
      A      = 8'd200;
      B      = 8'd100;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ccr !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ccr got=%b expected=%b", ccr, 4'b0000);
      end else
         $display("reset_ccr ccr=%b ok", ccr);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_arith();
      // expected = {out, V, C, N, Z}
      logic [3:0]  op_v [8] = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0};
      logic [7:0]  a_v  [8] = '{8'd200, 8'd10, 8'h7F, 8'd0, 8'd50, 8'h80, 8'h7F, 8'h55};
      logic [7:0]  b_v  [8] = '{8'd100, 8'd20, 8'h01, 8'd1, 8'd20, 8'h01, 8'hFF, 8'h80};
      logic [11:0] e_v  [8] = '{{8'h2C, 4'b0100}, {8'h1E, 4'b0000}, {8'h80, 4'b1010},
                                {8'hFF, 4'b0110}, {8'h1E, 4'b0000}, {8'h7F, 4'b1000},
                                {8'h80, 4'b1110}, {8'h80, 4'b0010}};
      for (int i = 0; i < 8; i++) begin
         drive(op_v[i], 2'b00, a_v[i], b_v[i]);
         checks++;
         if ({out, V, C, N, Z} !== e_v[i]) begin
            failures++;
            $display("FAIL arith[%0d] op=%0d a=%h b=%h got out=%h VCNZ=%b expected out=%h VCNZ=%b",
                     i, op_v[i], a_v[i], b_v[i], out, {V, C, N, Z}, e_v[i][11:4], e_v[i][3:0]);
         end else
            $display("arith[%0d] op=%0d a=%h b=%h out=%h VCNZ=%b ok",
                     i, op_v[i], a_v[i], b_v[i], out, {V, C, N, Z});
      end
   endtask

   task automatic test_logic();
      logic [3:0]  op_v [3] = '{4'd4, 4'd5, 4'd4};
      logic [7:0]  a_v  [3] = '{8'hF0, 8'h12, 8'hFF};
      logic [7:0]  b_v  [3] = '{8'h0F, 8'h34, 8'hA5};
      logic [11:0] e_v  [3] = '{{8'h00, 4'b0001}, {8'h36, 4'b0000}, {8'hA5, 4'b0010}};
      for (int i = 0; i < 3; i++) begin
         drive(op_v[i], 2'b11, a_v[i], b_v[i]);
         checks++;
         if ({out, V, C, N, Z} !== e_v[i]) begin
            failures++;
            $display("FAIL logic[%0d] op=%0d a=%h b=%h got out=%h VCNZ=%b expected out=%h VCNZ=%b",
                     i, op_v[i], a_v[i], b_v[i], out, {V, C, N, Z}, e_v[i][11:4], e_v[i][3:0]);
         end else
            $display("logic[%0d] op=%0d a=%h b=%h out=%h VCNZ=%b ok",
                     i, op_v[i], a_v[i], b_v[i], out, {V, C, N, Z});
      end
   endtask

   task automatic test_rotate();
      logic [1:0]  r_v [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
      logic [7:0]  b_v [5] = '{8'h96, 8'h69, 8'h5A, 8'hFF, 8'h41};
      logic [11:0] e_v [5] = '{{8'h2D, 4'b0100}, {8'hB4, 4'b0110}, {8'h00, 4'b0101},
                               {8'h00, 4'b0001}, {8'h82, 4'b0010}};
      for (int i = 0; i < 5; i++) begin
         drive(4'd6, r_v[i], 8'hFF, b_v[i]);
         checks++;
         if ({out, V, C, N, Z} !== e_v[i]) begin
            failures++;
            $display("FAIL rot[%0d] ra=%b b=%h got out=%h VCNZ=%b expected out=%h VCNZ=%b",
                     i, r_v[i], b_v[i], out, {V, C, N, Z}, e_v[i][11:4], e_v[i][3:0]);
         end else
            $display("rot[%0d] ra=%b b=%h out=%h VCNZ=%b ok", i, r_v[i], b_v[i], out, {V, C, N, Z});
      end
   endtask

   task automatic test_unary();
      logic [1:0]  r_v [9] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
      logic [7:0]  b_v [9] = '{8'h0F, 8'h01, 8'h80, 8'h00, 8'hFF, 8'h7F, 8'h00, 8'h80, 8'h01};
      logic [11:0] e_v [9] = '{{8'hF0, 4'b0010}, {8'hFF, 4'b0010}, {8'h80, 4'b1010},
                               {8'h00, 4'b0101}, {8'h00, 4'b0101}, {8'h80, 4'b1010},
                               {8'hFF, 4'b0110}, {8'h7F, 4'b1000}, {8'h00, 4'b0001}};
      for (int i = 0; i < 9; i++) begin
         drive(4'd8, r_v[i], 8'hC3, b_v[i]);
         checks++;
         if ({out, V, C, N, Z} !== e_v[i]) begin
            failures++;
            $display("FAIL unary[%0d] ra=%b b=%h got out=%h VCNZ=%b expected out=%h VCNZ=%b",
                     i, r_v[i], b_v[i], out, {V, C, N, Z}, e_v[i][11:4], e_v[i][3:0]);
         end else
            $display("unary[%0d] ra=%b b=%h out=%h VCNZ=%b ok", i, r_v[i], b_v[i], out, {V, C, N, Z});
      end
   endtask

   task automatic test_passthrough();
      logic [3:0]  op_v [4] = '{4'd0, 4'd7, 4'd9, 4'd15};
      logic [7:0]  b_v  [4] = '{8'h80, 8'h00, 8'h3C, 8'hFF};
      logic [11:0] e_v  [4] = '{{8'h80, 4'b0010}, {8'h00, 4'b0001}, {8'h3C, 4'b0000},
                                {8'hFF, 4'b0010}};
      for (int i = 0; i < 4; i++) begin
         drive(op_v[i], 2'b10, 8'hFF, b_v[i]);
         checks++;
         if ({out, V, C, N, Z} !== e_v[i]) begin
            failures++;
            $display("FAIL pass[%0d] op=%0d b=%h got out=%h VCNZ=%b expected out=%h VCNZ=%b",
                     i, op_v[i], b_v[i], out, {V, C, N, Z}, e_v[i][11:4], e_v[i][3:0]);
         end else
            $display("pass[%0d] op=%0d b=%h out=%h VCNZ=%b ok", i, op_v[i], b_v[i], out, {V, C, N, Z});
      end
   endtask

   task automatic test_ccr();
      // INC FF -> capture, then non-flag ops hold, then SUB captures again.
      logic [3:0] op_v [5] = '{4'd8, 4'd9, 4'd3, 4'd7, 4'd1};
      logic [1:0] r_v  [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
      logic [7:0] a_v  [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      logic [7:0] b_v  [5] = '{8'hFF, 8'h80, 8'h01, 8'hFF, 8'h00};
      logic [3:0] e_v  [5] = '{4'b0101, 4'b0101, 4'b0110, 4'b0110, 4'b0110};
      for (int i = 0; i < 5; i++) begin
         drive(op_v[i], r_v[i], a_v[i], b_v[i]);
         @(posedge clk);
         #1;
         checks++;
         if (ccr !== e_v[i]) begin
            failures++;
            $display("FAIL ccr[%0d] op=%0d got=%b expected=%b", i, op_v[i], ccr, e_v[i]);
         end else
            $display("ccr[%0d] op=%0d ccr=%b ok", i, op_v[i], ccr);
      end
   endtask

   task automatic test_back_to_back();
      // Flag-affecting ops on consecutive edges each overwrite ccr.
      logic [3:0] op_v [4] = '{4'd2, 4'd4, 4'd6, 4'd8};
      logic [1:0] r_v  [4] = '{2'b00, 2'b00, 2'b10, 2'b01};
      logic [7:0] a_v  [4] = '{8'h7F, 8'hF0, 8'h00, 8'h00};
      logic [7:0] b_v  [4] = '{8'h01, 8'h0F, 8'h00, 8'h80};
      logic [3:0] e_v  [4] = '{4'b1010, 4'b0001, 4'b0101, 4'b1010};
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         opcode = op_v[i];
         ra     = r_v[i];
         A      = a_v[i];
         B      = b_v[i];
         @(posedge clk);
         #1;
         checks++;
         if (ccr !== e_v[i]) begin
            failures++;
            $display("FAIL b2b[%0d] op=%0d got=%b expected=%b", i, op_v[i], ccr, e_v[i]);
         end else
            $display("b2b[%0d] op=%0d ccr=%b ok", i, op_v[i], ccr);
      end
      // Reset mid-stream clears ccr even with a flag op applied.
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ccr !== 4'b0000) begin
         failures++;
         $display("FAIL b2b_reset got=%b expected=%b", ccr, 4'b0000);
      end else
         $display("b2b_reset ccr=%b ok", ccr);
      rst = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      A        = 8'h00;
      B        = 8'h00;
      opcode   = 4'd0;
      ra       = 2'b00;
      test_reset();
      test_arith();
      test_logic();
      test_rotate();
      test_unary();
      test_passthrough();
      test_ccr();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
